// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill/flush sequencer: same-cycle hit, one-line refill, then tag commit.
// Latency: hit 0 cycles; miss-to-resp = 1 + req wait + beats + 1 + 1 cycles.
// Backpressure: holds mem_req until mem_req_ready; refill beats may gap; cpu_stall outside IDLE.
// Optional: ICACHE_PERF_CNT_EN adds hit/miss performance counters (tied to 0 otherwise).
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int BEAT_CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req_valid,
    input  logic [31:0] cpu_addr,
    output logic        cpu_resp_valid,
    output logic        cpu_stall,
    output logic [5:0]  tag_lookup_index,
    output logic [21:0] tag_lookup_tag,
    input  logic        tag_hit,
    output logic        tag_update_valid,
    output logic [5:0]  tag_update_index,
    output logic [21:0] tag_update_tag,
    output logic        tag_flush_all,
    output logic        data_we,
    output logic [5:0]  data_index,
    output logic [1:0]  data_word_sel,
    output logic [31:0] data_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        flush_req,
    output logic        flush_done,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MISS_REQ = 3'd1,
        REFILL   = 3'd2,
        COMMIT   = 3'd3,
        FLUSH    = 3'd4
    } state_t;

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(LINE_WORDS - 1);

    state_t                state, state_nxt;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic                  flush_pending;
    logic [21:0]           miss_tag;
    logic [5:0]            miss_idx;
    logic                  flush_go;
    logic                  miss_go;
    logic                  unused_addr_off;

    // Offset bits select the word inside the data array, not used here.
    assign unused_addr_off = ^cpu_addr[3:0];

    // Lookup always presents the live fetch address to the tag array.
    assign tag_lookup_index = cpu_addr[9:4];
    assign tag_lookup_tag   = cpu_addr[31:10];

    // A flush (new or deferred) wins over a simultaneous fetch in IDLE.
    assign flush_go = flush_req | flush_pending;
    assign miss_go  = cpu_req_valid & ~tag_hit & ~flush_go;

    // State, beat counter, pending-flush flag and latched miss address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            flush_pending <= 1'b0;
            miss_tag      <= '0;
            miss_idx      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && miss_go) begin
                miss_tag <= cpu_addr[31:10];
                miss_idx <= cpu_addr[9:4];
            end
            if (state == MISS_REQ && mem_req_ready)
                beat_cnt <= '0;
            else if (state == REFILL && mem_resp_valid)
                beat_cnt <= beat_cnt + 1'b1;
            // Flush requests arriving mid-refill are held until the line commits.
            if (state == FLUSH)
                flush_pending <= 1'b0;
            else if (state != IDLE && flush_req)
                flush_pending <= 1'b1;
        end
    end

    // Next-state and all per-state outputs.
    always_comb begin
        state_nxt        = state;
        cpu_resp_valid   = 1'b0;
        cpu_stall        = 1'b1;
        tag_update_valid = 1'b0;
        tag_update_index = '0;
        tag_update_tag   = '0;
        tag_flush_all    = 1'b0;
        data_we          = 1'b0;
        data_index       = '0;
        data_word_sel    = '0;
        data_wdata       = '0;
        mem_req_valid    = 1'b0;
        mem_req_addr     = '0;
        flush_done       = 1'b0;
        case (state)
            IDLE: begin
                cpu_resp_valid = cpu_req_valid & tag_hit & ~flush_go;
                cpu_stall      = cpu_req_valid & (~tag_hit | flush_go);
                if (flush_go)
                    state_nxt = FLUSH;
                else if (miss_go)
                    state_nxt = MISS_REQ;
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {miss_tag, miss_idx, 4'b0000};
                if (mem_req_ready)
                    state_nxt = REFILL;
            end
            REFILL: begin
                data_index    = miss_idx;
                data_word_sel = 2'(beat_cnt);
                if (mem_resp_valid) begin
                    data_we    = 1'b1;
                    data_wdata = mem_resp_data;
                    if (beat_cnt == LAST_BEAT)
                        state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                tag_update_valid = 1'b1;
                tag_update_index = miss_idx;
                tag_update_tag   = miss_tag;
                state_nxt        = (flush_pending | flush_req) ? FLUSH : IDLE;
            end
            FLUSH: begin
                tag_flush_all = 1'b1;
                flush_done    = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Wrapping hit/miss counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cpu_resp_valid)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state == IDLE && miss_go)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`else
    assign perf_hit_cnt  = 32'h0;
    assign perf_miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: miss/refill/commit, hits, request stall,
// deferred flush, IDLE flush priority, mid-refill reset, and perf counters.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid;
    logic [31:0] cpu_addr;
    logic        cpu_resp_valid;
    logic        cpu_stall;
    logic [5:0]  tag_lookup_index;
    logic [21:0] tag_lookup_tag;
    logic        tag_hit;
    logic        tag_update_valid;
    logic [5:0]  tag_update_index;
    logic [21:0] tag_update_tag;
    logic        tag_flush_all;
    logic        data_we;
    logic [5:0]  data_index;
    logic [1:0]  data_word_sel;
    logic [31:0] data_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        flush_req;
    logic        flush_done;
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_addr(cpu_addr),
        .cpu_resp_valid(cpu_resp_valid), .cpu_stall(cpu_stall),
        .tag_lookup_index(tag_lookup_index), .tag_lookup_tag(tag_lookup_tag),
        .tag_hit(tag_hit),
        .tag_update_valid(tag_update_valid), .tag_update_index(tag_update_index),
        .tag_update_tag(tag_update_tag), .tag_flush_all(tag_flush_all),
        .data_we(data_we), .data_index(data_index), .data_word_sel(data_word_sel),
        .data_wdata(data_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .flush_req(flush_req), .flush_done(flush_done),
        .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_hits;
        logic [31:0] exp_miss;

        rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_addr = '0; tag_hit = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; flush_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_stall",      {31'b0, cpu_stall},        32'd0);
        chk("rst_resp",       {31'b0, cpu_resp_valid},   32'd0);
        chk("rst_mem_req",    {31'b0, mem_req_valid},    32'd0);
        chk("rst_tag_upd",    {31'b0, tag_update_valid}, 32'd0);
        chk("rst_flush_done", {31'b0, flush_done},       32'd0);
        chk("rst_data_we",    {31'b0, data_we},          32'd0);

        // Miss on 0x0000_1040: idx 0x04, tag 0x000004.
        cpu_req_valid = 1'b1; cpu_addr = 32'h0000_1040; tag_hit = 1'b0;
        #1;
        chk("miss_stall",   {31'b0, cpu_stall},      32'd1);
        chk("miss_resp",    {31'b0, cpu_resp_valid}, 32'd0);
        chk("lookup_index", {26'b0, tag_lookup_index}, 32'h04);
        chk("lookup_tag",   {10'b0, tag_lookup_tag},   32'h000004);
        tick();

        // Memory not ready for 5 cycles; stray beats must be ignored.
        for (int i = 0; i < 5; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_0000 + i;
            #1;
            chk("wait_mem_req",  {31'b0, mem_req_valid}, 32'd1);
            chk("wait_addr",     mem_req_addr,           32'h0000_1040);
            chk("wait_stall",    {31'b0, cpu_stall},     32'd1);
            chk("wait_no_write", {31'b0, data_we},       32'd0);
            tick();
        end
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("ready_addr", mem_req_addr, 32'h0000_1040);
        tick();
        mem_req_ready = 1'b0;

        // Four beats A0..A3 with a gap after beat 1.
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hA0 + i;
            #1;
            chk("beat_we",    {31'b0, data_we},          32'd1);
            chk("beat_sel",   {30'b0, data_word_sel},    i);
            chk("beat_data",  data_wdata,                32'hA0 + i);
            chk("beat_index", {26'b0, data_index},       32'h04);
            chk("beat_noupd", {31'b0, tag_update_valid}, 32'd0);
            tick();
            if (i == 1) begin
                mem_resp_valid = 1'b0;
                #1;
                chk("gap_no_write", {31'b0, data_we}, 32'd0);
                tick();
            end
        end
        mem_resp_valid = 1'b0;
        #1;
        chk("commit_valid", {31'b0, tag_update_valid}, 32'd1);
        chk("commit_index", {26'b0, tag_update_index}, 32'h04);
        chk("commit_tag",   {10'b0, tag_update_tag},   32'h000004);
        chk("commit_stall", {31'b0, cpu_stall},        32'd1);
        tick();
        chk("commit_once", {31'b0, tag_update_valid}, 32'd0);

        // Re-lookup hits in the same cycle; three hit cycles in total.
        tag_hit = 1'b1;
        #1;
        chk("hit_resp",   {31'b0, cpu_resp_valid}, 32'd1);
        chk("hit_stall",  {31'b0, cpu_stall},      32'd0);
        chk("hit_no_mem", {31'b0, mem_req_valid},  32'd0);
        tick();
        chk("hit2_resp", {31'b0, cpu_resp_valid}, 32'd1);
        tick();
        chk("hit3_resp", {31'b0, cpu_resp_valid}, 32'd1);
        tick();
        cpu_req_valid = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
        exp_hits = 32'd3; exp_miss = 32'd1;
`else
        exp_hits = 32'd0; exp_miss = 32'd0;
`endif
        #1;
        chk("perf_hits", perf_hit_cnt,  exp_hits);
        chk("perf_miss", perf_miss_cnt, exp_miss);

        // Miss on 0x0000_2080 (idx 0x08, tag 0x000008) with flush during beat 2.
        cpu_req_valid = 1'b1; cpu_addr = 32'h0000_2080; tag_hit = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hB0 + i;
            flush_req = (i == 2);
            #1;
            chk("fl_beat_we", {31'b0, data_we}, 32'd1);
            chk("fl_no_flush", {31'b0, tag_flush_all}, 32'd0);
            tick();
        end
        mem_resp_valid = 1'b0; flush_req = 1'b0; tag_hit = 1'b1;
        #1;
        chk("fl_commit_valid", {31'b0, tag_update_valid}, 32'd1);
        chk("fl_commit_tag",   {10'b0, tag_update_tag},   32'h000008);
        chk("fl_commit_index", {26'b0, tag_update_index}, 32'h08);
        chk("fl_commit_noflush", {31'b0, tag_flush_all},  32'd0);
        tick();
        chk("fl_flush_all",  {31'b0, tag_flush_all},  32'd1);
        chk("fl_done",       {31'b0, flush_done},     32'd1);
        chk("fl_no_resp",    {31'b0, cpu_resp_valid}, 32'd0);
        chk("fl_stall",      {31'b0, cpu_stall},      32'd1);
        tick();
        chk("fl_done_once",  {31'b0, flush_done},     32'd0);
        chk("fl_idle_resp",  {31'b0, cpu_resp_valid}, 32'd1);

        // Flush in IDLE beats a simultaneous hitting request.
        flush_req = 1'b1;
        #1;
        chk("prio_stall", {31'b0, cpu_stall},      32'd1);
        chk("prio_resp",  {31'b0, cpu_resp_valid}, 32'd0);
        tick();
        flush_req = 1'b0; cpu_req_valid = 1'b0;
        #1;
        chk("prio_flush_done", {31'b0, flush_done}, 32'd1);
        tick();
        chk("prio_back_idle", {31'b0, cpu_stall}, 32'd0);

        // Reset after beat 1 of a refill drops it; late beats are ignored.
        cpu_req_valid = 1'b1; cpu_addr = 32'h0000_3000; tag_hit = 1'b0;
        tick();
        cpu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hC0 + i;
            tick();
        end
        mem_resp_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hC2;
        #1;
        chk("rr_stall",   {31'b0, cpu_stall},     32'd0);
        chk("rr_mem_req", {31'b0, mem_req_valid}, 32'd0);
        chk("rr_late_we", {31'b0, data_we},       32'd0);
        chk("rr_wdata",   data_wdata,             32'd0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("rr_no_commit", {31'b0, tag_update_valid}, 32'd0);
        chk("rr_perf_hits", perf_hit_cnt,  32'd0);
        chk("rr_perf_miss", perf_miss_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
